base64_stream_ctrl: RTL and testbench

BASE64_STREAM_CTRL -- requirements
Module: base64_stream_ctrl

---
 rtl/base64_pkg.sv | 24 ++
 rtl/base64_stream_ctrl_if.sv | 31 +++
 rtl/base64_bitbuf.sv | 55 +++++
 rtl/base64_stream_ctrl.sv | 95 +++++++++
 tb/tb_base64_stream_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/base64_pkg.sv
`default_nettype none
// ============================================================================
// Module  : base64_pkg
// Brief   : Shared widths and FSM state encoding for the base64 stream path.
// Revision: 1.0
// ============================================================================
package base64_pkg;

    localparam int ASCII_W = 7;
    localparam int B64_W   = 6;
    localparam int BUF_W   = 12;
    localparam int GROUP   = 4;
    localparam int LEN_W   = $clog2(BUF_W + 1);
    localparam int CNT_W   = $clog2(GROUP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2,
        ST_PAD  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/base64_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : base64_stream_ctrl_if
// Brief   : ASCII-in / base64-symbol-out handshake bundle.
// Revision: 1.0
// ============================================================================
interface base64_stream_ctrl_if;
    import base64_pkg::*;

    logic               in_valid;
    logic [ASCII_W-1:0] in_ascii;
    logic               in_last;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [B64_W-1:0]   out_code;
    logic               out_pad;
    logic               out_last;

    modport master (
        output in_valid, in_ascii, in_last, out_ready,
        input  in_ready, out_valid, out_code, out_pad, out_last
    );

    modport slave (
        input  in_valid, in_ascii, in_last, out_ready,
        output in_ready, out_valid, out_code, out_pad, out_last
    );

endinterface
`default_nettype wire

// File: rtl/base64_bitbuf.sv
`default_nettype none
// ============================================================================
// Module  : base64_bitbuf
// Brief   : MSB-aligned 12-bit bit buffer with fill count; loads 7, drains 6.
// Revision: 1.0
// ============================================================================
module base64_bitbuf
    import base64_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               load_i,
    input  wire logic [ASCII_W-1:0] ascii_i,
    input  wire logic               shift_i,
    input  wire logic               flush_i,
    output logic      [B64_W-1:0]   code_o,
    output logic      [LEN_W-1:0]   len_o
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [BUF_W-1:0] aligned;

    always_comb begin
        // New character lands directly below the bits already held.
        aligned = {ascii_i, {(BUF_W - ASCII_W){1'b0}}} >> len_q;
        buf_d   = buf_q;
        len_d   = len_q;
        if (load_i) begin
            buf_d = buf_q | aligned;
            len_d = len_q + LEN_W'(ASCII_W);
        end else if (shift_i) begin
            buf_d = buf_q << B64_W;
            len_d = len_q - LEN_W'(B64_W);
        end else if (flush_i) begin
            buf_d = '0;
            len_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            len_q <= '0;
        end else begin
            buf_q <= buf_d;
            len_q <= len_d;
        end
    end

    assign code_o = buf_q[BUF_W-1 -: B64_W];
    assign len_o  = len_q;

endmodule
`default_nettype wire

// File: rtl/base64_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : base64_stream_ctrl
// Brief   : Streams 7-bit ASCII into base64 indices with pad and last marking.
// Revision: 1.0
// ============================================================================
module base64_stream_ctrl
    import base64_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    base64_stream_ctrl_if.slave bus,
    output logic                busy
);

    localparam logic [LEN_W-1:0] LEN_SYM  = LEN_W'(B64_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [B64_W-1:0] buf_code;
    logic [LEN_W-1:0] len;
    logic             accept, out_fire, shift, flush, has_word, has_part;

    base64_bitbuf u_bitbuf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .ascii_i (bus.in_ascii),
        .shift_i (shift),
        .flush_i (flush),
        .code_o  (buf_code),
        .len_o   (len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

    always_comb begin
        has_word      = (len >= LEN_SYM);
        has_part      = (len != '0) && !has_word;
        bus.in_ready  = rst && (state_q == ST_IDLE || state_q == ST_RUN) && !has_word;
        accept        = bus.in_valid && bus.in_ready;
        bus.out_valid = 1'b0;
        bus.out_code  = '0;
        bus.out_pad   = 1'b0;
        bus.out_last  = 1'b0;
        state_d       = state_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = bus.in_last ? ST_TAIL : ST_RUN;
            end
            ST_RUN: begin
                if (has_word) begin
                    bus.out_valid = 1'b1;
                    bus.out_code  = buf_code;
                end
                if (accept && bus.in_last) state_d = ST_TAIL;
            end
            ST_TAIL: begin
                if (has_word || has_part) begin
                    bus.out_valid = 1'b1;
                    bus.out_code  = buf_code;
                    // Last only if this symbol empties the buffer and closes a group.
                    bus.out_last  = (has_part || len == LEN_SYM) && (sym_cnt_q == CNT_LAST);
                end else begin
                    state_d = (sym_cnt_q != '0) ? ST_PAD : ST_IDLE;
                end
            end
            ST_PAD: begin
                bus.out_valid = 1'b1;
                bus.out_pad   = 1'b1;
                bus.out_last  = (sym_cnt_q == CNT_LAST);
                if (bus.out_ready && sym_cnt_q == CNT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        out_fire  = bus.out_valid && bus.out_ready;
        shift     = out_fire && has_word;
        flush     = out_fire && has_part;
        sym_cnt_d = out_fire ? sym_cnt_q + 1'b1 : sym_cnt_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_base64_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_base64_stream_ctrl
// Brief   : Random and directed messages checked against a base64 reference queue.
// Revision: 1.0
// ============================================================================
module tb_base64_stream_ctrl;
    import base64_pkg::*;

    typedef logic [ASCII_W-1:0] msg_q_t[$];

    logic clk;
    logic rst;
    logic busy;

    base64_stream_ctrl_if bus();

    base64_stream_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    int         checks   = 0;
    int         failures = 0;
    int         sym_seen = 0;
    logic [7:0] exp_q[$];   // {code, pad, last}
    bit         abort      = 1'b0;
    bit         stall      = 1'b0;
    bit         rand_ready = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: concatenate bits MSB first, cut into 6-bit groups, pad to 4.
    task automatic push_expected(input msg_q_t m);
        bit         bits[$];
        int         nd;
        logic [5:0] c;
        logic [7:0] e;
        foreach (m[i]) for (int b = ASCII_W - 1; b >= 0; b--) bits.push_back(m[i][b]);
        nd = 0;
        while (bits.size() > 0) begin
            for (int k = 5; k >= 0; k--) c[k] = (bits.size() > 0) ? bits.pop_front() : 1'b0;
            exp_q.push_back({c, 1'b0, 1'b0});
            nd++;
        end
        repeat ((4 - nd % 4) % 4) exp_q.push_back({6'd0, 1'b1, 1'b0});
        e = exp_q.pop_back();
        e[0] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic send_char(input logic [ASCII_W-1:0] c, input logic l);
        int t = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_ascii = c;
        bus.in_last  = l;
        do begin @(negedge clk); t++; end while (!bus.in_ready && t < 300 && !abort);
        if (!abort) begin
            if (!bus.in_ready) begin
                checks++; failures++;
                $display("FAIL in_accept_timeout actual=no_ready required=ready at %0t", $time);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_ascii = 7'($urandom);
    endtask

    task automatic send_msg(input msg_q_t m);
        push_expected(m);
        foreach (m[i]) begin
            if (abort) break;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_char(m[i], (i == m.size() - 1));
        end
    endtask

    task automatic rand_msg(input int n, output msg_q_t m);
        m = {};
        repeat (n) m.push_back(7'($urandom));
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        do begin @(negedge clk); t++; end while ((busy || exp_q.size() != 0) && t < 2000);
        check(name, {30'd0, busy, (exp_q.size() == 0)}, 32'd1);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall) bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every symbol transfer.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_out_exclusive", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_symbol actual=code%0d required=none at %0t", bus.out_code, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("sym_code", 32'(bus.out_code), 32'(e[7:2]));
                        check("sym_pad",  32'(bus.out_pad),  32'(e[1]));
                        check("sym_last", 32'(bus.out_last), 32'(e[0]));
                    end
                    sym_seen++;
                end
            end
        end
    end

    initial begin
        msg_q_t m;
        int     base;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_ascii = '0;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_code",  32'(bus.out_code),  32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        m = '{7'h41};
        push_expected(m);
        send_char(7'h41, 1'b1);
        @(negedge clk);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        wait_idle("done_A");

        m = '{7'h41, 7'h42};
        send_msg(m);
        wait_idle("done_AB");

        rand_msg(3, m); send_msg(m); wait_idle("done_3ch");
        rand_msg(6, m); send_msg(m); wait_idle("done_6ch");

        // Backpressure mid-message.
        rand_msg(6, m);
        base = sym_seen;
        fork
            send_msg(m);
            begin
                int         t = 0;
                logic [7:0] held;
                do begin @(posedge clk); #2; t++; end
                while (!(sym_seen >= base + 3 && bus.out_valid) && t < 1000);
                stall = 1'b1;
                bus.out_ready = 1'b0;
                held = {bus.out_code, bus.out_pad, bus.out_last};
                check("stall_entered", 32'(bus.out_valid), 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_hold", 32'({bus.out_code, bus.out_pad, bus.out_last}), 32'(held));
                    check("stall_no_input", 32'(bus.in_ready), 32'd0);
                end
                @(posedge clk); #2;
                stall = 1'b0;
                bus.out_ready = 1'b1;
            end
        join
        wait_idle("done_stall");

        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            rand_msg($urandom_range(1, 8), m);
            send_msg(m);
            wait_idle("done_rand");
        end
        rand_ready = 1'b0;

        // Reset after two symbols of a four-character message.
        rand_msg(4, m);
        base = sym_seen;
        fork
            send_msg(m);
            begin
                int t = 0;
                do begin @(posedge clk); t++; end while (sym_seen < base + 2 && t < 1000);
                #3;
                abort = 1'b1;
                rst   = 1'b0;
                exp_q.delete();
                #1;
                check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
                check("midrst_outs", 32'({bus.out_code, bus.out_pad, bus.out_last}), 32'd0);
                check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                repeat (2) @(posedge clk);
                #3 rst = 1'b1;
            end
        join
        abort = 1'b0;
        @(negedge clk);
        check("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("after_rst_out_valid", 32'(bus.out_valid), 32'd0);
        m = '{7'h41};
        send_msg(m);
        wait_idle("done_A_after_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
